// File: rtl/issue_dispatch_if.sv
`default_nettype none
// ============================================================================
// Module : issue_dispatch_pkg / issue_dispatch_if
// Brief  : Instruction payload type and the bus that connects the issue
//          buffer read side, the dispatcher and the EX-stage registers.
//
// Interface signals:
//   i_set1, i_set2  : head / second issue-buffer entries (slot a older)
//   i_is_valid      : {slot a valid, slot b valid}
//   o_using_num     : entries consumed this cycle (0, 1 or 2)
//   o_ex_set1/2     : EX-stage payload registers
//   o_ex_valid      : {EX slot a valid, EX slot b valid}
// Modports:
//   master : issue-buffer / environment side
//   slave  : dispatcher side
// Revision: 1.0 - initial release
// ============================================================================

package issue_dispatch_pkg;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic [3:0]  br_type;       // non-zero: branch / jump
    logic [3:0]  ldst_type;     // non-zero: memory access
    logic        mem_we;        // memory write (store) when a memory op
    logic        rf_we;
    logic [4:0]  rf_rd;
    logic [4:0]  rf_raddr1;
    logic [4:0]  rf_raddr2;
    logic        o_inst_lawful; // decoder marked the instruction legal
  } PC_set;

endpackage

interface issue_dispatch_if;
  import issue_dispatch_pkg::*;

  PC_set       i_set1;
  PC_set       i_set2;
  logic [1:0]  i_is_valid;
  logic [1:0]  o_using_num;
  PC_set       o_ex_set1;
  PC_set       o_ex_set2;
  logic [1:0]  o_ex_valid;

  modport master (
    output i_set1, i_set2, i_is_valid,
    input  o_using_num, o_ex_set1, o_ex_set2, o_ex_valid
  );

  modport slave (
    input  i_set1, i_set2, i_is_valid,
    output o_using_num, o_ex_set1, o_ex_set2, o_ex_valid
  );

endinterface

`default_nettype wire

// File: rtl/issue_dispatch.sv
`default_nettype none
// ============================================================================
// Module : issue_dispatch
// Brief  : Issue-buffer read side. Examines the two head entries, issues
//          0, 1 or 2 of them in order, reports the consumed count and
//          registers issued instructions into the EX-stage registers.
//          Load-use hazards are tracked by a per-register down-counter
//          scoreboard; pair hazards follow in-order dual-issue rules.
//
// Ports:
//   clk          : clock, rising edge
//   rst          : asynchronous reset, active-high
//   flush_BR     : branch mispredict flush (issues nothing, kills EX valid)
//   stall_DCache : DCache miss stall (issues nothing, holds EX + scoreboard)
//   bus          : issue_dispatch_if.slave (entries in, count + EX regs out)
//   o_cnt_dual / o_cnt_single / o_cnt_hazard : 32-bit performance counters,
//                  present only when ISSUE_PERF_CNT_EN is defined
//
// Parameters:
//   LOAD_LAT : cycles a load destination stays busy after issue (1..3)
//   NREG     : architectural register count (scoreboard depth)
//
// Build option: define ISSUE_PERF_CNT_EN to add the performance counters.
// Revision: 1.0 - initial release
// ============================================================================

module issue_dispatch
  import issue_dispatch_pkg::*;
#(
  parameter int LOAD_LAT = 2,
  parameter int NREG     = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  input  wire logic         flush_BR,
  input  wire logic         stall_DCache,
  issue_dispatch_if.slave   bus
`ifdef ISSUE_PERF_CNT_EN
  ,
  output logic [31:0]       o_cnt_dual,
  output logic [31:0]       o_cnt_single,
  output logic [31:0]       o_cnt_hazard
`endif
);

  localparam logic [1:0] c_load_lat = 2'(LOAD_LAT);

  // Scoreboard: one busy down-counter per architectural register
  logic [1:0]      r_sb_cnt [NREG];
  logic [NREG-1:0] w_busy;

  PC_set      r_ex_set1;
  PC_set      r_ex_set2;
  logic [1:0] r_ex_valid;

  PC_set w_a;
  PC_set w_b;
  assign w_a = bus.i_set1;
  assign w_b = bus.i_set2;

  // Per-slot decode
  logic w_a_mem, w_a_load, w_a_br, w_a_writes;
  logic w_b_mem, w_b_load, w_b_writes;
  assign w_a_mem    = (w_a.ldst_type != 4'd0);
  assign w_a_load   = w_a_mem && !w_a.mem_we;
  assign w_a_br     = (w_a.br_type != 4'd0);
  assign w_a_writes = w_a.rf_we && (w_a.rf_rd != 5'd0);
  assign w_b_mem    = (w_b.ldst_type != 4'd0);
  assign w_b_load   = w_b_mem && !w_b.mem_we;
  assign w_b_writes = w_b.rf_we && (w_b.rf_rd != 5'd0);

  // r0 is never busy, so reads of r0 never raise a hazard
  always_comb begin
    w_busy = '0;
    for (int r = 1; r < NREG; r++) begin
      w_busy[r] = (r_sb_cnt[r] != 2'd0);
    end
  end

  logic w_haz_a, w_haz_b, w_raw_ab, w_waw_ab;
  assign w_haz_a  = w_busy[w_a.rf_raddr1] || w_busy[w_a.rf_raddr2];
  assign w_haz_b  = w_busy[w_b.rf_raddr1] || w_busy[w_b.rf_raddr2];
  assign w_raw_ab = w_a_writes &&
                    (((w_b.rf_raddr1 != 5'd0) && (w_b.rf_raddr1 == w_a.rf_rd)) ||
                     ((w_b.rf_raddr2 != 5'd0) && (w_b.rf_raddr2 == w_a.rf_rd)));
  assign w_waw_ab = w_a_writes && w_b_writes && (w_a.rf_rd == w_b.rf_rd);

  // Slot b alone (i_is_valid = 01) is illegal and never issues since it
  // requires issue_a.
  logic w_issue_a, w_issue_b;
  assign w_issue_a = bus.i_is_valid[1] && !w_haz_a && !stall_DCache && !flush_BR;
  assign w_issue_b = w_issue_a && bus.i_is_valid[0] && !w_haz_b &&
                     !w_raw_ab && !w_waw_ab && !(w_a_mem && w_b_mem) &&
                     !w_a_br && w_a.o_inst_lawful;

  logic [1:0] w_using_num;
  assign w_using_num     = w_issue_b ? 2'b10 : (w_issue_a ? 2'b01 : 2'b00);
  assign bus.o_using_num = w_using_num;

  // EX registers: flush > stall > normal. A non-issued slot is still
  // captured, only its valid bit is cleared.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ex_set1  <= '0;
      r_ex_set2  <= '0;
      r_ex_valid <= 2'b00;
    end else if (flush_BR) begin
      r_ex_valid <= 2'b00;
    end else if (!stall_DCache) begin
      r_ex_set1  <= w_a;
      r_ex_set2  <= w_b;
      r_ex_valid <= {w_issue_a, w_issue_b};
    end
  end

  assign bus.o_ex_set1  = r_ex_set1;
  assign bus.o_ex_set2  = r_ex_set2;
  assign bus.o_ex_valid = r_ex_valid;

  // Scoreboard: frozen on stall, otherwise decrement; a newly issued load
  // overrides the decrement of its destination. Flush leaves counters
  // alone because already-issued loads still complete. The mem-pair rule
  // guarantees at most one load issues per cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        r_sb_cnt[r] <= 2'd0;
      end
    end else if (!stall_DCache) begin
      for (int r = 0; r < NREG; r++) begin
        if (r_sb_cnt[r] != 2'd0) begin
          r_sb_cnt[r] <= r_sb_cnt[r] - 2'd1;
        end
      end
      if (w_issue_a && w_a_load && w_a_writes) begin
        r_sb_cnt[w_a.rf_rd] <= c_load_lat;
      end else if (w_issue_b && w_b_load && w_b_writes) begin
        r_sb_cnt[w_b.rf_rd] <= c_load_lat;
      end
    end
  end

`ifdef ISSUE_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_cnt_dual   <= 32'd0;
      o_cnt_single <= 32'd0;
      o_cnt_hazard <= 32'd0;
    end else if (!stall_DCache) begin
      if (w_using_num == 2'b10) o_cnt_dual   <= o_cnt_dual + 32'd1;
      if (w_using_num == 2'b01) o_cnt_single <= o_cnt_single + 32'd1;
      if (bus.i_is_valid[1] && !flush_BR && (w_using_num == 2'b00)) begin
        o_cnt_hazard <= o_cnt_hazard + 32'd1;
      end
    end
  end
`endif

endmodule

`default_nettype wire

// File: doc/issue_dispatch.md
Name: issue_dispatch

Overview:
- Read side of the issue buffer: examines the two head entries, decides to issue 0, 1 or 2 of them, and returns the consumed count as `o_using_num`.
- Issued instructions are registered into the EX-stage pipeline registers.
- Load-use hazards are tracked by a per-register scoreboard. Structural and intra-pair hazards are resolved by in-order dual-issue rules.
- Sits between the issue buffer and the EX stage.

Parameters:
- LOAD_LAT, 2, cycles a load destination stays busy after issue (1..3).
- NREG, 32, architectural register count (scoreboard depth).

Ports:
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  asynchronous reset, active-high
- i_set1  input  PC_set  head entry from issue buffer (slot a, older)
- i_set2  input  PC_set  second entry (slot b, younger)
- i_is_valid  input  2  {slot a valid, slot b valid}; 2'b10 = only slot a valid
- flush_BR  input  1  branch mispredict flush
- stall_DCache  input  1  DCache miss stall
- o_using_num  output  2  entries consumed this cycle (combinational): 2'b00 = 0, 2'b01 = 1, 2'b10 = 2
- o_ex_set1  output  PC_set  EX slot a register
- o_ex_set2  output  PC_set  EX slot b register
- o_ex_valid  output  2  {EX slot a valid, EX slot b valid}

Behaviour:
- Reset: asynchronous, active-high.
  - `o_ex_valid` = 2'b00; `o_ex_set1` and `o_ex_set2` = all-zero PC_set.
  - All scoreboard counters = 0.
- Derived per-slot signals:
  - is_mem = (ldst_type != 0)
  - is_load = is_mem && !mem_we
  - is_br = (br_type != 0)
  - writes = rf_we && rf_rd != 0
- Scoreboard:
  - One 2-bit down-counter per register; register r is busy when cnt[r] != 0.
  - Register 0 is never busy.
- Hazard on a slot: rf_raddr1 or rf_raddr2 of that slot is busy. Reads of r0 are ignored.
- Slot a issues (issue_a) when all hold:
  - i_is_valid[1]
  - no scoreboard hazard on slot a
  - !stall_DCache
  - !flush_BR
- Slot b issues (issue_b) only when all hold:
  - issue_a and i_is_valid[0]
  - no scoreboard hazard on slot b
  - no RAW: slot a writes and slot a rf_rd equals a non-zero rf_raddr1/rf_raddr2 of slot b
  - no WAW: both write the same rf_rd
  - not (slot a is_mem and slot b is_mem)
  - slot a not is_br
  - slot a o_inst_lawful = 1
- `o_using_num`:
  - 2'b10 if issue_a && issue_b
  - 2'b01 if issue_a only
  - 2'b00 otherwise
  - Never 2'b11.
  - Zero while flush or stall is high.
- EX register update, priority flush > stall > normal:
  - flush: `o_ex_valid` <= 00; set payloads don't care.
  - stall: hold all EX registers and `o_ex_valid`.
  - normal: `o_ex_set1` <= i_set1 and `o_ex_set2` <= i_set2; `o_ex_valid` <= {issue_a, issue_b}.
  - A non-issued slot is captured but marked invalid.
- Scoreboard update each cycle:
  - stall: counters frozen; no set.
  - Otherwise every non-zero counter decrements by 1.
  - Then an issued load that writes sets cnt[rf_rd] <= LOAD_LAT; set overrides decrement.
  - At most one load per cycle, guaranteed by the mem-pair rule.
  - flush does not clear counters: older issued loads still complete.
- Latency:
  - Dependent on a load: issues no earlier than LOAD_LAT+1 cycles after the load issued, absent stalls.
  - ALU-to-ALU dependence across cycles: no stall (EX forwarding owns it).
- Boundaries:
  - i_is_valid = 00 gives using_num 0.
  - i_is_valid = 01 (slot b valid without slot a) is illegal; treat as 00.
  - Reset mid-stall clears everything immediately.

Optional Feature:
- Macro ISSUE_PERF_CNT_EN.
- Defined: adds three 32-bit output ports, each reset to 0, wrapping, and frozen during stall:
  - o_cnt_dual: +1 per cycle with using_num 2
  - o_cnt_single: +1 per cycle with using_num 1
  - o_cnt_hazard: +1 per cycle with i_is_valid[1]=1, no stall/flush, and using_num 0
- Undefined: ports and logic absent; behaviour otherwise identical.

Test Plan:
- Two independent ALU ops (r1<=r2+r3, r4<=r5+r6), i_is_valid=11 -> using_num=2'b10; next cycle o_ex_valid=11.
- Pair r1<=r2+r3, r7<=r1+r4 -> using_num=2'b01; next cycle o_ex_valid=10; following cycle the old slot b (now slot a) issues.
- Load r5 issued; next instruction reads r5, LOAD_LAT=2 -> using_num=0 for 2 cycles, issues on 3rd; the r5 counter reads 2,1,0.
- Load+store pair, both valid -> using_num=01. Branch in slot a with a valid ALU op in slot b -> using_num=01.
- stall_DCache high for 3 cycles with a pending load -> using_num=0, EX regs held, counter frozen; after deassert it resumes decrementing from its frozen value.
- flush_BR with i_is_valid=11 -> using_num=0, next o_ex_valid=00, scoreboard unchanged. rst asserted mid-run -> o_ex_valid=00 and all counters 0 asynchronously.
